// File: rtl/exe_branch_unit.sv
// EXE-stage branch/jump resolver with a registered result and a 2-bit
// saturating-counter branch history table shared with fetch.
module exe_branch_unit #(
    parameter int          DATA_WIDTH  = 32,
    parameter int          ADDR_WIDTH  = 32,
    parameter int          BHT_ENTRIES = 64,
    parameter logic [1:0]  CTR_INIT    = 2'b01
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] inst_i,
    input  logic [ADDR_WIDTH-1:0] inst_addr_i,
    input  logic [DATA_WIDTH-1:0] op1_i,
    input  logic [DATA_WIDTH-1:0] op2_i,
    input  logic                  pred_taken_i,
    input  logic [ADDR_WIDTH-1:0] pred_addr_i,
    input  logic [ADDR_WIDTH-1:0] query_addr_i,
    output logic                  query_taken_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  jump_enable_o,
    output logic [ADDR_WIDTH-1:0] jump_addr_o,
    output logic [ADDR_WIDTH-1:0] link_addr_o,
    output logic                  redirect_o,
    output logic [ADDR_WIDTH-1:0] redirect_addr_o,
    output logic                  misalign_o
);
    localparam int IDX_W = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // ---------------- decode / resolve ----------------
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic                  is_b, is_jal, is_jalr, is_ctl, cond;
    logic                  taken, misalign, redirect;
    logic [ADDR_WIDTH-1:0] imm_b, imm_j, imm_i, target, link, next_pc;

    always_comb begin
        opcode  = inst_i[6:0];
        funct3  = inst_i[14:12];
        // reserved funct3 010/011 is treated like a non-control instruction
        is_b    = (opcode == OP_BRANCH) && (funct3[2:1] != 2'b01);
        is_jal  = (opcode == OP_JAL);
        is_jalr = (opcode == OP_JALR);
        is_ctl  = is_b | is_jal | is_jalr;

        imm_b = {{(ADDR_WIDTH-12){inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
        imm_j = {{(ADDR_WIDTH-20){inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
        imm_i = {{(ADDR_WIDTH-12){inst_i[31]}}, inst_i[31:20]};

        case (funct3)
            3'b000:  cond = (op1_i == op2_i);
            3'b001:  cond = (op1_i != op2_i);
            3'b100:  cond = ($signed(op1_i) <  $signed(op2_i));
            3'b101:  cond = ($signed(op1_i) >= $signed(op2_i));
            3'b110:  cond = (op1_i <  op2_i);
            3'b111:  cond = (op1_i >= op2_i);
            default: cond = 1'b0;
        endcase

        target = '0;
        if (is_b)    target = inst_addr_i + imm_b;
        if (is_jal)  target = inst_addr_i + imm_j;
        if (is_jalr) target = (ADDR_WIDTH'(op1_i) + imm_i) & ~ADDR_WIDTH'(1);

        taken    = (is_b & cond) | is_jal | is_jalr;
        link     = inst_addr_i + ADDR_WIDTH'(4);
        next_pc  = taken ? target : link;
        misalign = taken & (target[1:0] != 2'b00);
        // misaligned targets go to the trap unit instead of redirecting fetch
        redirect = is_ctl & ~misalign &
                   ((taken != pred_taken_i) | (taken & (target != pred_addr_i)));
    end

    // ---------------- handshake / output register ----------------
    logic                  valid_q, valid_d;
    logic                  jump_en_q, jump_en_d;
    logic [ADDR_WIDTH-1:0] jump_addr_q, jump_addr_d;
    logic [ADDR_WIDTH-1:0] link_q, link_d;
    logic                  redirect_q, redirect_d;
    logic [ADDR_WIDTH-1:0] redirect_addr_q, redirect_addr_d;
    logic                  misalign_q, misalign_d;
    logic                  accept;

    assign ready_o = (~valid_q | ready_i) & ~flush_i;
    assign accept  = valid_i & ready_o;

    always_comb begin
        valid_d         = valid_q;
        jump_en_d       = jump_en_q;
        jump_addr_d     = jump_addr_q;
        link_d          = link_q;
        redirect_d      = redirect_q;
        redirect_addr_d = redirect_addr_q;
        misalign_d      = misalign_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (ready_o) begin
            valid_d = valid_i;
        end
        if (accept) begin
            jump_en_d       = taken & ~misalign;
            jump_addr_d     = target;
            link_d          = link;
            redirect_d      = redirect;
            redirect_addr_d = next_pc;
            misalign_d      = misalign;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q         <= 1'b0;
            jump_en_q       <= 1'b0;
            jump_addr_q     <= '0;
            link_q          <= '0;
            redirect_q      <= 1'b0;
            redirect_addr_q <= '0;
            misalign_q      <= 1'b0;
        end else begin
            valid_q         <= valid_d;
            jump_en_q       <= jump_en_d;
            jump_addr_q     <= jump_addr_d;
            link_q          <= link_d;
            redirect_q      <= redirect_d;
            redirect_addr_q <= redirect_addr_d;
            misalign_q      <= misalign_d;
        end
    end

    assign valid_o         = valid_q;
    assign jump_enable_o   = jump_en_q;
    assign jump_addr_o     = jump_addr_q;
    assign link_addr_o     = link_q;
    assign redirect_o      = redirect_q;
    assign redirect_addr_o = redirect_addr_q;
    assign misalign_o      = misalign_q;

    // ---------------- branch history table ----------------
    logic [1:0]       bht_q [BHT_ENTRIES];
    logic [1:0]       bht_d [BHT_ENTRIES];
    logic [IDX_W-1:0] upd_idx, qry_idx;
    logic             train;
    logic             unused_addr_bits;

    assign upd_idx = inst_addr_i[IDX_W+1:2];
    assign qry_idx = query_addr_i[IDX_W+1:2];
    assign train   = accept & is_b;
    assign unused_addr_bits = ^{query_addr_i[ADDR_WIDTH-1:IDX_W+2], query_addr_i[1:0]};

    always_comb begin
        bht_d = bht_q;
        if (train) begin
            if (taken && bht_q[upd_idx] != 2'b11)
                bht_d[upd_idx] = bht_q[upd_idx] + 2'b01;
            else if (!taken && bht_q[upd_idx] != 2'b00)
                bht_d[upd_idx] = bht_q[upd_idx] - 2'b01;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= CTR_INIT;
        end else begin
            bht_q <= bht_d;
        end
    end

    // reads the registered table, so a same-cycle update is not visible yet
    assign query_taken_o = bht_q[qry_idx][1];

endmodule

// File: tb/tb_exe_branch_unit.sv
// Directed-vector bench for exe_branch_unit: resolution, redirect, misalign,
// BHT training, backpressure, flush and reset.
module tb_exe_branch_unit;
    logic        clk_i = 1'b0;
    logic        rst_i, flush_i, valid_i, ready_i, pred_taken_i;
    logic [31:0] inst_i, inst_addr_i, op1_i, op2_i, pred_addr_i, query_addr_i;
    logic        ready_o, query_taken_o, valid_o, jump_enable_o, redirect_o, misalign_o;
    logic [31:0] jump_addr_o, link_addr_o, redirect_addr_o;
    // second instance with weakly-taken reset value
    logic        ready2, qtaken2, valid2, jen2, redir2, mis2;
    logic [31:0] jaddr2, laddr2, raddr2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    exe_branch_unit u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
        .inst_i(inst_i), .inst_addr_i(inst_addr_i), .op1_i(op1_i), .op2_i(op2_i),
        .pred_taken_i(pred_taken_i), .pred_addr_i(pred_addr_i), .query_addr_i(query_addr_i),
        .query_taken_o(query_taken_o), .valid_o(valid_o), .ready_i(ready_i),
        .jump_enable_o(jump_enable_o), .jump_addr_o(jump_addr_o), .link_addr_o(link_addr_o),
        .redirect_o(redirect_o), .redirect_addr_o(redirect_addr_o), .misalign_o(misalign_o)
    );

    exe_branch_unit #(.CTR_INIT(2'b10)) u_dut2 (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready2),
        .inst_i(inst_i), .inst_addr_i(inst_addr_i), .op1_i(op1_i), .op2_i(op2_i),
        .pred_taken_i(pred_taken_i), .pred_addr_i(pred_addr_i), .query_addr_i(query_addr_i),
        .query_taken_o(qtaken2), .valid_o(valid2), .ready_i(ready_i),
        .jump_enable_o(jen2), .jump_addr_o(jaddr2), .link_addr_o(laddr2),
        .redirect_o(redir2), .redirect_addr_o(raddr2), .misalign_o(mis2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_jal(input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [11:0] imm);
        return {imm, 5'd1, 3'b000, 5'd1, 7'b1100111};
    endfunction

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] a,
                         input logic [31:0] b, input logic pt, input logic [31:0] pa);
        valid_i = 1'b1; inst_i = inst; inst_addr_i = pc;
        op1_i = a; op2_i = b; pred_taken_i = pt; pred_addr_i = pa;
    endtask

    // one accept, result sampled on the following falling edge
    task automatic send(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] a,
                        input logic [31:0] b, input logic pt, input logic [31:0] pa);
        @(negedge clk_i);
        drive(inst, pc, a, b, pt, pa);
        @(negedge clk_i);
        valid_i = 1'b0;
    endtask

    localparam logic [31:0] ADDI = 32'h0010_0093;

    initial begin
        rst_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1; pred_taken_i = 1'b0;
        inst_i = '0; inst_addr_i = '0; op1_i = '0; op2_i = '0; pred_addr_i = '0; query_addr_i = '0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);

        // reset state
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_jen", {31'd0, jump_enable_o}, 32'd0);
        check("rst_jaddr", jump_addr_o, 32'd0);
        check("rst_link", link_addr_o, 32'd0);
        check("rst_redir", {31'd0, redirect_o}, 32'd0);
        check("rst_raddr", redirect_addr_o, 32'd0);
        check("rst_mis", {31'd0, misalign_o}, 32'd0);
        check("rst_ready", {31'd0, ready_o}, 32'd1);
        for (int i = 0; i < 64; i++) begin
            query_addr_i = i * 4;
            #1;
            check("rst_q01", {31'd0, query_taken_o}, 32'd0);
            check("rst_q10", {31'd0, qtaken2}, 32'd1);
        end

        // BLT signed: -1 < 1 taken, predicted not taken
        send(enc_b(3'b100, 13'd16), 32'h100, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0);
        check("blt_valid", {31'd0, valid_o}, 32'd1);
        check("blt_jen", {31'd0, jump_enable_o}, 32'd1);
        check("blt_jaddr", jump_addr_o, 32'h110);
        check("blt_redir", {31'd0, redirect_o}, 32'd1);
        check("blt_raddr", redirect_addr_o, 32'h110);

        // BLTU same operands: 0xFFFFFFFF < 1 false
        send(enc_b(3'b110, 13'd16), 32'h100, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0);
        check("bltu_jen", {31'd0, jump_enable_o}, 32'd0);
        check("bltu_redir", {31'd0, redirect_o}, 32'd0);
        check("bltu_raddr", redirect_addr_o, 32'h104);

        // JALR: 0x2003+4 -> 0x2006 (bit1 set => misaligned)
        send(enc_jalr(12'd4), 32'h300, 32'h2003, 32'd0, 1'b1, 32'h2006);
        check("jalr_jaddr", jump_addr_o, 32'h2006);
        check("jalr_link", link_addr_o, 32'h304);
        check("jalr_redir", {31'd0, redirect_o}, 32'd0);
        check("jalr_mis", {31'd0, misalign_o}, 32'd1);
        check("jalr_jen", {31'd0, jump_enable_o}, 32'd0);

        // JAL backwards, correctly predicted then mispredicted target
        send(enc_jal(21'h1F_FFF8), 32'h1000, 32'd0, 32'd0, 1'b1, 32'hFF8);
        check("jal_jen", {31'd0, jump_enable_o}, 32'd1);
        check("jal_jaddr", jump_addr_o, 32'hFF8);
        check("jal_link", link_addr_o, 32'h1004);
        check("jal_redir", {31'd0, redirect_o}, 32'd0);
        send(enc_jal(21'h1F_FFF8), 32'h1000, 32'd0, 32'd0, 1'b1, 32'hFFC);
        check("jal_bad_redir", {31'd0, redirect_o}, 32'd1);
        check("jal_bad_raddr", redirect_addr_o, 32'hFF8);

        // BEQ not taken but predicted taken
        send(enc_b(3'b000, 13'd8), 32'h200, 32'd1, 32'd2, 1'b1, 32'h208);
        check("beq_nt_jen", {31'd0, jump_enable_o}, 32'd0);
        check("beq_nt_redir", {31'd0, redirect_o}, 32'd1);
        check("beq_nt_raddr", redirect_addr_o, 32'h204);

        // BNE not taken, predicted not taken, junk pred_addr
        send(enc_b(3'b001, 13'd8), 32'h204, 32'd5, 32'd5, 1'b0, 32'hDEAD_0000);
        check("bne_nt_redir", {31'd0, redirect_o}, 32'd0);

        // BGE signed: -1 >= 1 false ; BGEU unsigned true
        send(enc_b(3'b101, 13'd32), 32'h400, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0);
        check("bge_jen", {31'd0, jump_enable_o}, 32'd0);
        send(enc_b(3'b111, 13'h1FE0), 32'h400, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0);
        check("bgeu_jen", {31'd0, jump_enable_o}, 32'd1);
        check("bgeu_jaddr", jump_addr_o, 32'h3E0);

        // non-branch predicted taken: no jump, no redirect
        send(ADDI, 32'h500, 32'd0, 32'd0, 1'b1, 32'h600);
        check("addi_valid", {31'd0, valid_o}, 32'd1);
        check("addi_jen", {31'd0, jump_enable_o}, 32'd0);
        check("addi_redir", {31'd0, redirect_o}, 32'd0);

        // BHT: four taken BEQs at 0x40 back to back, query sees pre-update value
        @(negedge clk_i);
        query_addr_i = 32'h40;
        drive(enc_b(3'b000, 13'd8), 32'h40, 32'd5, 32'd5, 1'b1, 32'h48);
        #1 check("bht_q_pre1", {31'd0, query_taken_o}, 32'd0);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk_i);
            check("bht_stream_valid", {31'd0, valid_o}, 32'd1);
            check("bht_stream_jaddr", jump_addr_o, 32'h48);
            check("bht_q_pre", {31'd0, query_taken_o}, 32'd1);
        end
        @(negedge clk_i);
        valid_i = 1'b0;
        check("bht_stream_last", {31'd0, valid_o}, 32'd1);
        check("bht_q_sat", {31'd0, query_taken_o}, 32'd1);
        // saturated at 3: two not-taken give 2 then 1
        send(enc_b(3'b000, 13'd8), 32'h40, 32'd1, 32'd2, 1'b0, 32'd0);
        check("bht_dec1", {31'd0, query_taken_o}, 32'd1);
        send(enc_b(3'b000, 13'd8), 32'h40, 32'd1, 32'd2, 1'b0, 32'd0);
        check("bht_dec2", {31'd0, query_taken_o}, 32'd0);

        // entry 0xC0 -> 2, then untouched by reserved funct3 and non-branch
        query_addr_i = 32'hC0;
        send(enc_b(3'b000, 13'd8), 32'hC0, 32'd3, 32'd3, 1'b0, 32'd0);
        check("bht_c0_inc", {31'd0, query_taken_o}, 32'd1);
        send(enc_b(3'b010, 13'd8), 32'hC0, 32'd1, 32'd2, 1'b1, 32'hC8);
        check("rsv_jen", {31'd0, jump_enable_o}, 32'd0);
        check("rsv_redir", {31'd0, redirect_o}, 32'd0);
        check("rsv_bht", {31'd0, query_taken_o}, 32'd1);
        send(ADDI, 32'hC0, 32'd0, 32'd0, 1'b0, 32'd0);
        check("addi_bht", {31'd0, query_taken_o}, 32'd1);

        // flush with a pending output and a valid input
        @(negedge clk_i);
        ready_i = 1'b0;
        send(ADDI, 32'h900, 32'd0, 32'd0, 1'b0, 32'd0);
        check("fl_pending", {31'd0, valid_o}, 32'd1);
        drive(enc_b(3'b001, 13'd8), 32'hC0, 32'd7, 32'd7, 1'b0, 32'd0);
        flush_i = 1'b1; ready_i = 1'b1;
        #1 check("fl_ready", {31'd0, ready_o}, 32'd0);
        @(negedge clk_i);
        valid_i = 1'b0; flush_i = 1'b0;
        check("fl_valid", {31'd0, valid_o}, 32'd0);
        check("fl_bht", {31'd0, query_taken_o}, 32'd1);
        send(enc_b(3'b001, 13'd8), 32'hC0, 32'd7, 32'd7, 1'b0, 32'd0);
        check("bht_c0_dec", {31'd0, query_taken_o}, 32'd0);

        // backpressure: result held 5 cycles, then stream resumes at 1/cycle
        @(negedge clk_i);
        ready_i = 1'b0;
        send(enc_jal(21'h20), 32'h500, 32'd0, 32'd0, 1'b1, 32'h520);
        drive(enc_b(3'b000, 13'h10), 32'h600, 32'd1, 32'd1, 1'b1, 32'h610);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_ready", {31'd0, ready_o}, 32'd0);
            check("bp_valid", {31'd0, valid_o}, 32'd1);
            check("bp_jaddr", jump_addr_o, 32'h520);
            @(negedge clk_i);
        end
        ready_i = 1'b1;
        #1 check("bp_release_ready", {31'd0, ready_o}, 32'd1);
        @(negedge clk_i);
        check("bp_b_jaddr", jump_addr_o, 32'h610);
        drive(enc_jal(21'h40), 32'h700, 32'd0, 32'd0, 1'b1, 32'h740);
        @(negedge clk_i);
        valid_i = 1'b0;
        check("bp_c_valid", {31'd0, valid_o}, 32'd1);
        check("bp_c_jaddr", jump_addr_o, 32'h740);

        // reset mid-operation re-initialises the table and drops the result
        query_addr_i = 32'h40;
        send(enc_b(3'b000, 13'd8), 32'h40, 32'd4, 32'd4, 1'b1, 32'h48);
        check("pre_rst_bht", {31'd0, query_taken_o}, 32'd1);
        rst_i = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, valid_o}, 32'd0);
        check("mid_rst_bht", {31'd0, query_taken_o}, 32'd0);
        check("mid_rst_bht2", {31'd0, qtaken2}, 32'd1);
        @(negedge clk_i);
        rst_i = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
